jt12_timer_ctrl: RTL and testbench

JT12_TIMER_CTRL -- requirements
Module: jt12_timer_ctrl

---
 rtl/jt12_timer_ctrl.sv | 130 +++++++++++++
 tb/tb_jt12_timer_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: CPU write decoding for the timer registers 0x24..0x27 plus the status byte.
// Define JT12_TIMER_BUSY_EN to build the write-busy counter; otherwise busy is tied low.
module jt12_timer_ctrl #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [7:0] dout,
    output logic       busy,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic [1:0] ch3_mode
);
    logic       wr_prev_q, wr_prev_d;
    logic [7:0] sel_addr_q, sel_addr_d;
    logic       part_q, part_d;
    logic [9:0] value_a_q, value_a_d;
    logic [7:0] value_b_q, value_b_d;
    logic [3:0] ctl_q, ctl_d;
    logic [1:0] ch3_mode_q, ch3_mode_d;
    logic [1:0] clr_flag_q, clr_flag_d;
    logic       wr_now, wr_event, addr_wr, data_wr;

    always_comb begin
        wr_now     = ~cs_n & ~wr_n;
        wr_event   = wr_now & ~wr_prev_q;
        addr_wr    = wr_event & ~addr[0];
        data_wr    = wr_event & addr[0];
        wr_prev_d  = wr_now;
        sel_addr_d = sel_addr_q;
        part_d     = part_q;
        value_a_d  = value_a_q;
        value_b_d  = value_b_q;
        ctl_d      = ctl_q;
        ch3_mode_d = ch3_mode_q;
        clr_flag_d = 2'b00;
        if (addr_wr) begin
            sel_addr_d = din;
            part_d     = addr[1];
        end
        // Part II data writes only restart busy; register contents stay put.
        if (data_wr && !part_q) begin
            case (sel_addr_q)
                8'h24: value_a_d[9:2] = din;
                8'h25: value_a_d[1:0] = din[1:0];
                8'h26: value_b_d = din;
                8'h27: begin
                    ch3_mode_d = din[7:6];
                    ctl_d      = din[3:0];
                    clr_flag_d = din[5:4];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev_q  <= 1'b0;
            sel_addr_q <= 8'h00;
            part_q     <= 1'b0;
            value_a_q  <= 10'h000;
            value_b_q  <= 8'h00;
            ctl_q      <= 4'h0;
            ch3_mode_q <= 2'b00;
            clr_flag_q <= 2'b00;
        end else begin
            wr_prev_q  <= wr_prev_d;
            sel_addr_q <= sel_addr_d;
            part_q     <= part_d;
            value_a_q  <= value_a_d;
            value_b_q  <= value_b_d;
            ctl_q      <= ctl_d;
            ch3_mode_q <= ch3_mode_d;
            clr_flag_q <= clr_flag_d;
        end
    end

`ifdef JT12_TIMER_BUSY_EN
    localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);
    logic [5:0] busy_cnt_q, busy_cnt_d;

    // A new data write always wins over a simultaneous clk_en decrement.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (data_wr) begin
            busy_cnt_d = BUSY_LOAD;
        end else if (clk_en && busy_cnt_q != 6'd0) begin
            busy_cnt_d = busy_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= 6'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy = (busy_cnt_q != 6'd0);
`else
    // clk_en only gates the busy counter, so it has no effect in this build.
    assign busy = 1'b0 & clk_en;
`endif

    assign dout         = {busy, 5'b00000, flag_B, flag_A};
    assign value_A      = value_a_q;
    assign value_B      = value_b_q;
    assign load_A       = ctl_q[0];
    assign load_B       = ctl_q[1];
    assign enable_irq_A = ctl_q[2];
    assign enable_irq_B = ctl_q[3];
    assign ch3_mode     = ch3_mode_q;
    assign clr_flag_A   = clr_flag_q[0];
    assign clr_flag_B   = clr_flag_q[1];
endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Self-checking bench for jt12_timer_ctrl; expectations follow JT12_TIMER_BUSY_EN when defined.
module tb_jt12_timer_ctrl;
`ifdef JT12_TIMER_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, clk_en, cs_n, wr_n, flag_A, flag_B;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy, load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic [1:0] ch3_mode;

    int n_vec  = 0;
    int n_miss = 0;
    logic [25:0] exp_q[$];

    typedef struct {
        logic [1:0] addr;
        logic [7:0] din;
        logic [9:0] va;
        logic [7:0] vb;
        logic [5:0] ctl;
        logic [1:0] clr;
    } vec_t;
    vec_t tbl[17];

    jt12_timer_ctrl #(.BUSY_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n),
        .addr(addr), .din(din), .flag_A(flag_A), .flag_B(flag_B), .dout(dout),
        .busy(busy), .value_A(value_A), .value_B(value_B), .load_A(load_A),
        .load_B(load_B), .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .ch3_mode(ch3_mode)
    );

    always #5 clk = ~clk;

    // Packed view: {value_A, value_B, ch3_mode, irqB, irqA, loadB, loadA, clrB, clrA}.
    function automatic logic [25:0] mk(input logic [9:0] va, input logic [7:0] vb,
                                       input logic [5:0] ctl, input logic [1:0] clr);
        return {va, vb, ctl, clr};
    endfunction

    function logic [25:0] obs();
        return {value_A, value_B, ch3_mode, enable_irq_B, enable_irq_A, load_B, load_A,
                clr_flag_B, clr_flag_A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                            input logic [25:0] exp, input string name);
        logic [25:0] e;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, 32'(obs()), 32'(e));
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    // Data write, then clk_en every 6th clk; optional restart after rewrite_at enables.
    task automatic busy_run(input int rewrite_at, input int total, input string tag);
        int   n_en = 0;
        int   cyc = 0;
        bit   rewritten = 1'b0;
        logic exp_b;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h00; clk_en = 1'b0;
        for (int c = 0; c < 6 * (total + 3); c++) begin
            @(negedge clk);
            cs_n = 1'b1; wr_n = 1'b1;
            exp_b = BUSY_EN && (n_en < total);
            check({tag, "_busy"}, 32'(busy), 32'(exp_b));
            check({tag, "_dout"}, 32'(dout), {24'd0, exp_b, 7'h01});
            if (!rewritten && rewrite_at > 0 && n_en == rewrite_at) begin
                cs_n = 1'b0; wr_n = 1'b0; clk_en = 1'b0; rewritten = 1'b1;
            end else begin
                clk_en = (cyc % 6 == 5);
                if (clk_en) n_en++;
                cyc++;
            end
        end
        clk_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
        addr = 2'b00; din = 8'h00; flag_A = 1'b0; flag_B = 1'b0;
        #3;
        check("reset_regs", 32'(obs()), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{2'd0, 8'h24, 10'h000, 8'h00, 6'h00, 2'b00};
        tbl[1]  = '{2'd1, 8'hAB, 10'h2AC, 8'h00, 6'h00, 2'b00};
        tbl[2]  = '{2'd0, 8'h25, 10'h2AC, 8'h00, 6'h00, 2'b00};
        tbl[3]  = '{2'd1, 8'h03, 10'h2AF, 8'h00, 6'h00, 2'b00};
        tbl[4]  = '{2'd0, 8'h26, 10'h2AF, 8'h00, 6'h00, 2'b00};
        tbl[5]  = '{2'd1, 8'h5A, 10'h2AF, 8'h5A, 6'h00, 2'b00};
        tbl[6]  = '{2'd1, 8'hC3, 10'h2AF, 8'hC3, 6'h00, 2'b00};
        tbl[7]  = '{2'd0, 8'h27, 10'h2AF, 8'hC3, 6'h00, 2'b00};
        tbl[8]  = '{2'd1, 8'h35, 10'h2AF, 8'hC3, 6'h05, 2'b11};
        tbl[9]  = '{2'd1, 8'h25, 10'h2AF, 8'hC3, 6'h05, 2'b10};
        tbl[10] = '{2'd1, 8'hCA, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[11] = '{2'd0, 8'h30, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[12] = '{2'd1, 8'hFF, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[13] = '{2'd2, 8'h26, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[14] = '{2'd3, 8'h55, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[15] = '{2'd0, 8'h26, 10'h2AF, 8'hC3, 6'h3A, 2'b00};
        tbl[16] = '{2'd1, 8'h11, 10'h2AF, 8'h11, 6'h3A, 2'b00};
        for (int i = 0; i < 17; i++) begin
            do_write(tbl[i].addr, tbl[i].din, mk(tbl[i].va, tbl[i].vb, tbl[i].ctl, tbl[i].clr),
                     $sformatf("vec%0d", i));
        end

        do_write(2'd0, 8'h27, mk(10'h2AF, 8'h11, 6'h3A, 2'b00), "r27_addr");
        do_write(2'd1, 8'h35, mk(10'h2AF, 8'h11, 6'h05, 2'b11), "r27_data");
        @(negedge clk);
        check("r27_clr_drop", 32'(obs()), 32'(mk(10'h2AF, 8'h11, 6'h05, 2'b00)));

        do_write(2'd0, 8'h26, mk(10'h2AF, 8'h11, 6'h05, 2'b00), "hold_addr");
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h21;
        @(negedge clk);
        check("hold_first", 32'(obs()), 32'(mk(10'h2AF, 8'h21, 6'h05, 2'b00)));
        din = 8'h99;
        repeat (19) @(negedge clk);
        check("hold_once", 32'(obs()), 32'(mk(10'h2AF, 8'h21, 6'h05, 2'b00)));
        cs_n = 1'b1; wr_n = 1'b1;

        flag_A = 1'b1;
        do_write(2'd0, 8'h30, mk(10'h2AF, 8'h21, 6'h05, 2'b00), "busy_addr");
        clk_en = 1'b1;
        repeat (40) @(negedge clk);
        clk_en = 1'b0;
        check("drain_busy", 32'(busy), 32'd0);
        check("idle_dout", 32'(dout), 32'h01);

        busy_run(0, 32, "single");
        busy_run(10, 42, "extend");

        do_write(2'd2, 8'h26, mk(10'h2AF, 8'h21, 6'h05, 2'b00), "p2_addr");
        do_write(2'd3, 8'h55, mk(10'h2AF, 8'h21, 6'h05, 2'b00), "p2_data");
        check("p2_busy", 32'(busy), 32'(BUSY_EN));

        do_write(2'd0, 8'h24, mk(10'h2AF, 8'h21, 6'h05, 2'b00), "rst_addr");
        do_write(2'd1, 8'h12, mk(10'h04B, 8'h21, 6'h05, 2'b00), "rst_data");
        check("rst_pre_busy", 32'(busy), 32'(BUSY_EN));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_regs", 32'(obs()), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_dout", 32'(dout), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(2'd1, 8'hEE, mk(10'h000, 8'h00, 6'h00, 2'b00), "post_rst_addr0");
        check("post_rst_busy", 32'(busy), 32'(BUSY_EN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
